fft8_stream_ctrl: RTL

- Sequencer that puts the 8-point FFT core on a serial streaming interface.
- Collects 8 complex samples from a valid/ready input stream and presents them in parallel to the core.
- Holds the core inputs stable for the core's pipeline latency, then captures the 8 results.
- Replays the captured results serially on a valid/ready output stream. Processes one frame at a time, with status outputs for framing errors and a frame count.

---
 rtl/fft8_stream_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fft8_stream_ctrl.sv
// Streaming wrapper around an 8-point FFT core.
// Collects a frame, runs the core, then replays the bins.
module fft8_stream_ctrl #(
    parameter int DW          = 32,
    parameter int FFT_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    input  logic              s_last,
    output logic [8*DW-1:0]   core_in,
    output logic              core_start,
    input  logic [8*DW-1:0]   core_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [2:0]        m_index,
    output logic              m_last,
    output logic              busy,
    output logic              err_short,
    output logic              err_long,
    output logic [CNT_W-1:0]  frame_count
);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        UNLOAD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DW-1:0]     ibuf [8];
    logic [DW-1:0]     obuf [8];
    logic [2:0]        idx;
    logic [2:0]        oidx;
    logic [3:0]        wcnt;
    logic [8*DW-1:0]   frame_nxt;
    logic [8*DW-1:0]   core_in_q;
    logic              s_hs;
    logic              m_hs;
    logic              in_end;
    logic              wdone;
    logic              err_short_q;
    logic              err_long_q;

    assign s_hs   = s_valid && (state == LOAD);
    assign m_hs   = m_ready && (state == UNLOAD);
    assign in_end = s_hs && ((idx == 3'd7) || s_last);
    assign wdone  = (wcnt == FFT_LATENCY[3:0]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/status outputs
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        busy       = 1'b0;
        core_start = 1'b0;
        unique case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (in_end) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                core_start = (wcnt == 4'd0);
                if (wdone) begin
                    state_nxt = UNLOAD;
                end
            end
            UNLOAD: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                if (m_hs && (oidx == 3'd7)) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Frame as it will look after this handshake: earlier lanes,
    // current sample, and zeros above it for a short frame
    always_comb begin
        frame_nxt = '0;
        for (int k = 0; k < 8; k++) begin
            if (3'(k) < idx) begin
                frame_nxt[k*DW +: DW] = ibuf[k];
            end else if (3'(k) == idx) begin
                frame_nxt[k*DW +: DW] = s_data;
            end else begin
                frame_nxt[k*DW +: DW] = '0;
            end
        end
    end

    // Input buffer and write index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                ibuf[k] <= '0;
            end
            idx <= 3'd0;
        end else if (in_end) begin
            for (int k = 0; k < 8; k++) begin
                ibuf[k] <= frame_nxt[k*DW +: DW];
            end
            idx <= 3'd0;
        end else if (s_hs) begin
            ibuf[idx] <= s_data;
            idx       <= idx + 3'd1;
        end
    end

    // Core inputs latched once per frame, held through RUN and after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_in_q <= '0;
        end else if (in_end) begin
            core_in_q <= frame_nxt;
        end
    end

    assign core_in = core_in_q;

    // Wait counter for the core pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 4'd0;
        end else if (in_end) begin
            wcnt <= 4'd0;
        end else if (state == RUN) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // Capture core results on the last RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                obuf[k] <= '0;
            end
        end else if ((state == RUN) && wdone) begin
            for (int k = 0; k < 8; k++) begin
                obuf[k] <= core_out[k*DW +: DW];
            end
        end
    end

    // Output index and completed-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oidx        <= 3'd0;
            frame_count <= '0;
        end else if (m_hs) begin
            oidx <= oidx + 3'd1;
            if (oidx == 3'd7) begin
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

    // Framing error pulses, one cycle after the closing handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            err_short_q <= in_end && s_last && (idx != 3'd7);
            err_long_q  <= in_end && !s_last && (idx == 3'd7);
        end
    end

    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign m_data    = obuf[oidx];
    assign m_index   = oidx;
    assign m_last    = m_valid && (oidx == 3'd7);

endmodule
